wb_decode_mux: RTL and testbench
================================

// Module: wb_decode_mux
// PURPOSE
//  Parametrised 1-master / N-slave Wishbone B4 address-decode mux for the SoC I/O bus.
//  Decodes each new cycle into a single latched slave select and holds it for the whole transfer/burst.
//  Converts unmapped accesses and stalled slaves (bus watchdog) into master err, and records error status.
//  Sits between the core data/IO master and DMEM, IMEM, UART, GPIO, SPI and future slaves.
// PARAMETERS
//  NUM_SLAVES     5                      number of slave ports (1..16)
//  MATCH_ADDR     {NUM_SLAVES{32'h0}}    flat NUM_SLAVES*32 base addresses, slave i at bits [32*i+:32]
//  MATCH_MASK     {NUM_SLAVES{32'h0}}    flat NUM_SLAVES*32 masks; hit_i = (adr & MASK_i) == ADDR_i
//  TIMEOUT_CYCLES 255                    watchdog limit in cycles; 0 disables the watchdog
//  CNT_W          16                     width of the error counter
// PORTS
//  wb_clk_i      in   1            bus clock
//  wb_rst_ni     in   1            reset, asynchronous, active low
//  wbm_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  in  32/32/4/1/1/1/3/2  master request
//  wbm_dat_o     out  32           read data from the selected slave
//  wbm_ack_o     out  1            ack from the selected slave
//  wbm_err_o     out  1            slave err, or decode miss, or timeout
//  wbm_rty_o     out  1            rty from the selected slave
//  wbs_adr_o/dat_o/sel_o/we_o/cti_o/bte_o  out  N*32/N*32/N*4/N/N*3/N*2  broadcast request to every slave
//  wbs_cyc_o     out  N            cyc, asserted only to the selected slave
//  wbs_stb_o     out  N            stb, asserted only to the selected slave
//  wbs_dat_i/ack_i/err_i/rty_i  in  N*32/N/N/N  slave responses
//  err_count_o   out  CNT_W        saturating count of miss and timeout errors
//  err_adr_o     out  32           address of the most recent miss or timeout
//  err_cause_o   out  2            00 none, 01 decode miss, 10 timeout (latest error)
// BEHAVIOUR
//  Reset: FSM=IDLE; all wbs_cyc_o/wbs_stb_o=0; wbm_ack/err/rty_o=0; wbm_dat_o=0; err_count_o=0; err_adr_o=0; err_cause_o=0; sel_q=0.
//  Decode: lowest index wins when regions overlap. No hit means a miss.
//  FSM IDLE: on wbm_cyc_i&wbm_stb_i, register the decode.
//    Hit -> ACTIVE, sel_q = index.
//    Miss -> ERR, latch adr, cause=01.
//  ERR: wbm_err_o=1 for exactly one cycle, err_count++ (saturates at all-ones), then IDLE.
//  ACTIVE: wbs_cyc_o[sel_q]=wbm_cyc_i and wbs_stb_o[sel_q]=wbm_stb_i.
//    Responses route combinationally from slave sel_q. Added latency is one cycle in the first beat only.
//    Watchdog counts cycles with stb high and no ack/err/rty, and clears on any response.
//    On termination: if cti_i is 3'b000 or 3'b111 -> IDLE; otherwise stay ACTIVE (burst continues, no re-decode).
//    wbm_cyc_i falling -> IDLE immediately; no response is forwarded that cycle.
//    Watchdog reaches TIMEOUT_CYCLES -> TOUT.
//  TOUT: wbs_cyc/stb deasserted to all slaves; wbm_err_o=1 for one cycle.
//    Latch adr, cause=10, count++, then IDLE. A late slave ack arriving in TOUT or afterwards is dropped.
//  Simultaneous slave ack and timeout in the same cycle: the ack wins and the watchdog clears.
//  Slave responses from any index other than sel_q, or arriving while not ACTIVE, are ignored.
//  wbm_ack_o/err_o/rty_o are never asserted outside ACTIVE, ERR or TOUT. At most one is high per cycle (err>rty>ack).
//  Reset asserted mid-transfer forces IDLE asynchronously and drops all strobes. Error status clears.
// STRUCTURE
//  Package wb_pkg: typedef enum {IDLE, ACTIVE, ERR, TOUT} wbmux_state_e; cause codes ERR_NONE/ERR_MISS/ERR_TOUT; CTI_CLASSIC/CTI_EOB constants.
//  Sub-module wb_addr_decode: combinational priority decoder (adr -> hit, idx), reusable by later arbiters.
//  Top level contains the FSM, watchdog counter and error registers.
// TESTING
//  1. Classic read at 0x20000104 (GPIO, index 1), slave acks 2 cycles after stb -> only wbs_cyc_o[1] high; dat returned; ack count 1; FSM back to IDLE.
//  2. Read at 0x50000000 (unmapped) -> wbm_err_o pulses 2nd cycle after stb; err_count_o=1; err_adr_o=0x50000000; cause=01; no wbs_stb_o asserted.
//  3. TIMEOUT_CYCLES=8, slave never responds -> err at stb+9 cycles; wbs_stb_o dropped; cause=10; a late ack at +12 produces no wbm_ack_o.
//  4. 4-beat incrementing burst (cti 010, last 111) to DMEM at 0x00000040 -> one decode cycle, then 4 acks back-to-back on consecutive cycles; IDLE after beat 4.
//  5. Overlapping MATCH regions covering 0x10000000 for slaves 1 and 3 -> slave 1 selected. Mid-burst reset -> all wbs_cyc_o=0 in the same cycle; counters cleared.
//  6. 2^CNT_W+3 misses with CNT_W=4 -> err_count_o saturates at 4'hF.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone address-decode mux and its
// reusable decoder.
package wb_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, ERR, TOUT} wbmux_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_MISS = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // A terminated beat ends the cycle only for classic or end-of-burst tags.
  function automatic logic cti_last(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction
endpackage

// File: rtl/wb_decode_mux_if.sv
// Wishbone link bundle; N response/strobe lanes (N=1 for the master side,
// N=NUM_SLAVES for the broadcast slave side, where adr/dat_w are shared).
interface wb_decode_mux_if #(parameter int N = 1) ();
  logic [31:0]         adr;
  logic [31:0]         dat_w;
  logic [3:0]          sel;
  logic                we;
  logic [2:0]          cti;
  logic [1:0]          bte;
  logic [N-1:0]        cyc;
  logic [N-1:0]        stb;
  logic [N-1:0][31:0]  dat_r;
  logic [N-1:0]        ack;
  logic [N-1:0]        err;
  logic [N-1:0]        rty;

  modport master (output adr, dat_w, sel, we, cti, bte, cyc, stb,
                  input  dat_r, ack, err, rty);
  modport slave  (input  adr, dat_w, sel, we, cti, bte, cyc, stb,
                  output dat_r, ack, err, rty);
endinterface

// File: rtl/wb_addr_decode.sv
// Combinational priority address decoder: lowest matching index wins,
// hit=0 when no region matches.
module wb_addr_decode #(
  parameter int                         NUM_SLAVES = 5,
  parameter int                         IDX_W      = 3,
  parameter logic [NUM_SLAVES*32-1:0]   MATCH_ADDR = '0,
  parameter logic [NUM_SLAVES*32-1:0]   MATCH_MASK = '0
) (
  input  logic [31:0]      adr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);
  // Scanning downward lets the lowest matching index overwrite the others.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((adr & MATCH_MASK[32*i +: 32]) == MATCH_ADDR[32*i +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/wb_decode_mux.sv
// 1-master / N-slave Wishbone decode mux: latches one slave select per cycle,
// turns misses and watchdog expiries into master err and records them.
module wb_decode_mux
  import wb_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 5,
  parameter logic [NUM_SLAVES*32-1:0] MATCH_ADDR     = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0] MATCH_MASK     = {NUM_SLAVES{32'h0}},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter int                       CNT_W          = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  wb_decode_mux_if.slave    wbm,
  wb_decode_mux_if.master   wbs,
  output logic [CNT_W-1:0]  err_count_o,
  output logic [31:0]       err_adr_o,
  output logic [1:0]        err_cause_o
);
  localparam int  IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam bit  WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int  WD_W  = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  wbmux_state_e     state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      eadr_q, eadr_d;
  logic [1:0]       cause_q, cause_d;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             req, live, s_ack, s_err, s_rty, s_any;

  wb_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES), .IDX_W(IDX_W),
    .MATCH_ADDR(MATCH_ADDR), .MATCH_MASK(MATCH_MASK)
  ) u_dec (.adr(wbm.adr), .hit(dec_hit), .idx(dec_idx));

  assign req   = wbm.cyc[0] & wbm.stb[0];
  assign live  = (state_q == ACTIVE) && wbm.cyc[0];
  assign s_ack = wbs.ack[sel_q];
  assign s_err = wbs.err[sel_q];
  assign s_rty = wbs.rty[sel_q];
  assign s_any = s_ack | s_err | s_rty;

  assign wbs.adr   = wbm.adr;
  assign wbs.dat_w = wbm.dat_w;
  assign wbs.sel   = wbm.sel;
  assign wbs.we    = wbm.we;
  assign wbs.cti   = wbm.cti;
  assign wbs.bte   = wbm.bte;

  always_comb begin
    wbs.cyc = '0;
    wbs.stb = '0;
    if (state_q == ACTIVE) begin
      wbs.cyc[sel_q] = wbm.cyc[0];
      wbs.stb[sel_q] = wbm.stb[0];
    end
  end

  // Responses pass through only while the cycle is live; err > rty > ack.
  always_comb begin
    wbm.dat_r = '0;
    wbm.ack   = '0;
    wbm.err   = '0;
    wbm.rty   = '0;
    if (live) begin
      wbm.dat_r[0] = wbs.dat_r[sel_q];
      wbm.err[0]   = s_err;
      wbm.rty[0]   = s_rty & ~s_err;
      wbm.ack[0]   = s_ack & ~s_err & ~s_rty;
    end else if (state_q == ERR || state_q == TOUT) begin
      wbm.err[0]   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    eadr_d  = eadr_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (req) begin
          if (dec_hit) begin
            state_d = ACTIVE;
            sel_d   = dec_idx;
          end else begin
            state_d = ERR;
            eadr_d  = wbm.adr;
            cause_d = ERR_MISS;
            if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!wbm.cyc[0]) begin
          state_d = IDLE;
        end else if (s_any) begin
          // A response beats a same-cycle watchdog expiry.
          wd_d = '0;
          if (cti_last(wbm.cti)) state_d = IDLE;
        end else if (WD_EN && wbm.stb[0]) begin
          wd_d = wd_q + 1'b1;
          if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
            state_d = TOUT;
            eadr_d  = wbm.adr;
            cause_d = ERR_TOUT;
            if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ERR, TOUT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      eadr_q  <= '0;
      cause_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      eadr_q  <= eadr_d;
      cause_q <= cause_d;
    end
  end

  assign err_count_o = cnt_q;
  assign err_adr_o   = eadr_q;
  assign err_cause_o = cause_q;
endmodule

// File: tb/tb_wb_decode_mux.sv
// Randomised scoreboard bench for wb_decode_mux: master driver pushes expected
// responses, a negedge monitor pops and compares them.
module tb_wb_decode_mux;
  localparam int NS = 5;
  localparam int TO = 8;
  localparam int CW = 4;
  localparam logic [NS*32-1:0] MA = {32'h6000_0000, 32'h1000_0000, 32'h4000_0000,
                                     32'h0000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MM = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
                                     32'hC000_0000, 32'hF000_0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_decode_mux_if #(.N(1))  m ();
  wb_decode_mux_if #(.N(NS)) s ();
  logic [CW-1:0] err_count;
  logic [31:0]   err_adr;
  logic [1:0]    err_cause;

  wb_decode_mux #(.NUM_SLAVES(NS), .MATCH_ADDR(MA), .MATCH_MASK(MM),
                  .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbm(m), .wbs(s),
    .err_count_o(err_count), .err_adr_o(err_adr), .err_cause_o(err_cause));

  typedef struct { int kind; logic [31:0] dat; logic [NS-1:0] cyc; } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int spur = 0;

  // Slave behaviour knobs and reference-model error status.
  int            slv_lat = 0;
  int            slv_kind = 0;
  logic [NS-1:0] force_ack = '0;
  int            m_cnt = 0;
  logic [31:0]   m_adr = '0;
  int            m_cause = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Memory map as the SoC sees it; -1 means unmapped.
  function automatic int model_decode(input logic [31:0] a);
    if (a[31:28] == 4'h0) return 0;
    if (a[31:30] == 2'b00) return 1;
    if (a[31:28] == 4'h4) return 2;
    if (a[31:28] == 4'h6) return 4;
    return -1;
  endfunction

  function automatic void model_err(input logic [31:0] a, input int cause);
    m_cnt   = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
    m_adr   = a;
    m_cause = cause;
  endfunction

  // Slave models: respond to their own strobe after slv_lat wait cycles.
  initial begin
    int wc;
    wc = 0;
    s.ack = '0; s.err = '0; s.rty = '0; s.dat_r = '0;
    forever begin
      @(posedge clk); #2;
      s.ack = '0; s.err = '0; s.rty = '0;
      for (int i = 0; i < NS; i++) s.dat_r[i] = {4'(i), s.adr[27:0]} ^ s.dat_w;
      if (|(s.cyc & s.stb)) begin
        if (wc >= slv_lat) begin
          for (int i = 0; i < NS; i++)
            if (s.cyc[i] && s.stb[i]) begin
              if (slv_kind == 1) s.err[i] = 1'b1;
              else if (slv_kind == 2) s.rty[i] = 1'b1;
              else s.ack[i] = 1'b1;
            end
          wc = 0;
        end else wc++;
      end else wc = 0;
      s.ack = s.ack | force_ack;
    end
  end

  // Monitor
  initial begin
    exp_t e;
    int   k;
    forever begin
      @(negedge clk);
      if (rst_n && (m.ack[0] || m.err[0] || m.rty[0])) begin
        chk("resp_onehot", 32'($countones({m.ack[0], m.err[0], m.rty[0]})), 32'd1);
        if (q.size() == 0) begin
          spur++;
          checks++;
          errors++;
          $display("FAIL spurious_resp: got ack=%0b err=%0b rty=%0b want none",
                   m.ack[0], m.err[0], m.rty[0]);
        end else begin
          e = q.pop_front();
          k = m.err[0] ? 1 : (m.rty[0] ? 2 : 0);
          chk("resp_kind", k, e.kind);
          chk("wbs_cyc", 32'(s.cyc), 32'(e.cyc));
          if (e.kind == 0) chk("rd_dat", m.dat_r[0], e.dat);
        end
      end
    end
  end

  task automatic xfer(input logic [31:0] adr, input int beats, input int lat, input int kind);
    int idx;
    bit stop;
    idx = model_decode(adr);
    slv_lat = lat;
    slv_kind = kind;
    stop = 0;
    for (int b = 0; b < beats && !stop; b++) begin
      int   n;
      int   want_n;
      exp_t e;
      m.adr   = adr + 32'(4 * b);
      m.dat_w = $urandom;
      m.sel   = 4'($urandom);
      m.we    = 1'($urandom);
      m.bte   = 2'b00;
      m.cti   = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
      m.cyc   = 1'b1;
      m.stb   = 1'b1;
      if (idx < 0) begin
        e = '{kind: 1, dat: '0, cyc: '0};
        want_n = 2;
        model_err(m.adr, 1);
        stop = 1;
      end else if (lat >= TO) begin
        e = '{kind: 1, dat: '0, cyc: '0};
        want_n = TO + 1 + (b == 0 ? 1 : 0);
        model_err(m.adr, 2);
        stop = 1;
      end else begin
        e = '{kind: kind, dat: {4'(idx), m.adr[27:0]} ^ m.dat_w, cyc: NS'(1) << idx};
        want_n = lat + 1 + (b == 0 ? 1 : 0);
        if (kind != 0) stop = 1;
      end
      q.push_back(e);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(m.ack[0] || m.err[0] || m.rty[0]) && n < 40);
      chk("latency", n, want_n);
      if (n >= 40) begin
        stop = 1;
        q.delete();
      end
      @(posedge clk); #1;
    end
    m.cyc = 1'b0;
    m.stb = 1'b0;
    chk("err_count", 32'(err_count), m_cnt);
    chk("err_adr", err_adr, m_adr);
    chk("err_cause", 32'(err_cause), m_cause);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] a;
    int r, beats, lat, kind;
    m.adr = '0; m.dat_w = '0; m.sel = '0; m.we = 1'b0; m.cti = '0; m.bte = '0;
    m.cyc = 1'b0; m.stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wbs_cyc", 32'(s.cyc), 0);
    chk("rst_wbs_stb", 32'(s.stb), 0);
    chk("rst_resp", {29'd0, m.ack[0], m.err[0], m.rty[0]}, 0);
    chk("rst_dat", m.dat_r[0], 0);
    chk("rst_cnt", 32'(err_count), 0);
    chk("rst_adr", err_adr, 0);
    chk("rst_cause", 32'(err_cause), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(32'h2000_0104, 1, 2, 0);      // classic read to GPIO
    xfer(32'h5000_0000, 1, 0, 0);      // unmapped
    xfer(32'h2000_0200, 1, TO, 0);     // watchdog expiry
    @(posedge clk); force_ack = 5'b00010;
    repeat (3) @(posedge clk);
    force_ack = '0;
    #1;
    xfer(32'h0000_0040, 4, 0, 0);      // back-to-back burst
    xfer(32'h1000_0000, 1, 1, 0);      // overlap, slave 1 wins
    xfer(32'h6000_0010, 1, TO - 1, 0); // ack on the last legal cycle
    xfer(32'h6000_0020, 1, 1, 1);      // slave err is not a bus error
    xfer(32'h4000_0008, 1, 0, 2);      // rty
    force_ack = 5'b00010;              // foreign ack while slave 2 is selected
    xfer(32'h4000_0100, 1, 3, 0);
    force_ack = '0;

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: a = 32'h0000_0000;
        1: a = 32'h2000_0000;
        2: a = 32'h4000_0000;
        3: a = 32'h1000_0000;
        4: a = 32'h6000_0000;
        default: a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 28);
      endcase
      a = a | ($urandom & 32'h00FF_FFFC);
      beats = ($urandom_range(0, 1) == 1) ? 4 : 1;
      lat = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
      kind = (beats == 1) ? $urandom_range(0, 2) : 0;
      xfer(a, beats, lat, kind);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset in the middle of a burst.
    slv_lat = 100;
    m.adr = 32'h0000_0040; m.cti = 3'b010; m.cyc = 1'b1; m.stb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_cyc", 32'(s.cyc), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc", 32'(s.cyc), 0);
    chk("midrst_stb", 32'(s.stb), 0);
    chk("midrst_cnt", 32'(err_count), 0);
    chk("midrst_adr", err_adr, 0);
    chk("midrst_cause", 32'(err_cause), 0);
    m.cyc = 1'b0; m.stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_cnt = 0; m_adr = '0; m_cause = 0;
    @(posedge clk); #1;

    for (int t = 0; t < (1 << CW) + 3; t++)
      xfer(32'h5000_0000 | ($urandom & 32'h0FFF_FFFC), 1, 0, 0);
    chk("cnt_saturated", 32'(err_count), 32'hF);

    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    chk("no_spurious", spur, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
